// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared AHB encodings, arbiter state type and burst-length helper
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_BURST  = 2'd2,
        ST_LOCKED = 2'd3
    } arb_state_t;

    // Re-arbitration is allowed once at most this many beats remain.
    localparam logic [4:0] CNT_REARB_MAX = 5'd1;

    // Number of beats in a burst; undefined-length INCR counts as one beat.
    function automatic logic [4:0] burst_beats(input hburst_t burst);
        logic [4:0] beats;
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                      beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// rtl/ahb_arbiter_if.sv - arbitration signals between the bus masters and the arbiter
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int MASTER_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MASTER_W-1:0]    HMASTER;
    logic                   HMASTLOCK;

    // Master side: requests and the muxed address-phase controls go out, grants come back.
    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    // Arbiter side.
    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );

endinterface

// File: rtl/ahb_arb_pick.sv
// rtl/ahb_arb_pick.sv - combinational rotating picker: first requester after the start pointer
module ahb_arb_pick #(
    parameter  int NUM_MASTERS = 4,
    localparam int MASTER_W    = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [MASTER_W-1:0]    ptr_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   valid_o
);

    // Walk ptr+1, ptr+2, ... wrapping, ending on ptr itself; first requester wins.
    always_comb begin
        logic [MASTER_W-1:0] idx;
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = MASTER_W'((int'(ptr_i) + i) % NUM_MASTERS);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - AHB bus arbiter with burst/lock protection; AHB_ARB_FIXED_PRIO_EN selects fixed priority
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input logic          HCLK,
    input logic          HRESET,
    ahb_arbiter_if.slave bus
);

    localparam int                     MASTER_W = $clog2(NUM_MASTERS);
    localparam logic [MASTER_W-1:0]    DEF_IDX  = MASTER_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT  = NUM_MASTERS'(1) << DEFAULT_MASTER;

    function automatic logic [MASTER_W-1:0] oh2idx(input logic [NUM_MASTERS-1:0] oh);
        logic [MASTER_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) idx = MASTER_W'(i);
        end
        return idx;
    endfunction

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MASTER_W-1:0]    grant_idx, grant_d_idx;
    logic [MASTER_W-1:0]    hmaster_q;
    logic                   hmastlock_q;
    logic [4:0]             cnt_q, cnt_d;
    arb_state_t             state_q, state_d;
    htrans_t                htrans;
    hburst_t                hburst;
    logic                   rearb_ok;
    logic [MASTER_W-1:0]    pick_ptr;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;

    assign htrans    = htrans_t'(bus.HTRANS);
    assign hburst    = hburst_t'(bus.HBURST);
    assign grant_idx = oh2idx(grant_q);

`ifdef AHB_ARB_FIXED_PRIO_EN
    // Starting the search just past the top index makes master 0 the highest priority.
    assign pick_ptr = MASTER_W'(NUM_MASTERS - 1);
`else
    logic [MASTER_W-1:0] ptr_q;
    assign pick_ptr = ptr_q;
`endif

    ahb_arb_pick #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_pick (
        .req_i  (bus.HBUSREQ),
        .ptr_i  (pick_ptr),
        .gnt_o  (pick_gnt),
        .valid_o(pick_valid)
    );

    // Remaining-beat count of the address-phase owner after this transfer is accepted.
    always_comb begin
        cnt_d = cnt_q;
        case (htrans)
            HTRANS_IDLE:   cnt_d = '0;
            HTRANS_BUSY:   cnt_d = cnt_q;
            HTRANS_NONSEQ: cnt_d = burst_beats(hburst) - 5'd1;
            HTRANS_SEQ:    cnt_d = (cnt_q == '0) ? '0 : cnt_q - 5'd1;
            default:       cnt_d = cnt_q;
        endcase
    end

    // Grant moves only when no lock is held and the burst is on its last beat or done.
    always_comb begin
        rearb_ok = (state_q != ST_LOCKED) && !bus.HLOCK[grant_idx] && (cnt_d <= CNT_REARB_MAX);
        grant_d  = grant_q;
        if (rearb_ok) begin
            grant_d = pick_valid ? pick_gnt : DEF_GNT;
        end
        grant_d_idx = oh2idx(grant_d);
        // LOCKED follows the master holding the grant after this edge, so a fresh
        // locked grantee is protected from its very first cycle.
        if (bus.HLOCK[grant_d_idx]) begin
            state_d = ST_LOCKED;
        end else if (htrans == HTRANS_IDLE) begin
            state_d = ST_IDLE;
        end else if (cnt_d > CNT_REARB_MAX) begin
            state_d = ST_BURST;
        end else begin
            state_d = ST_OWNED;
        end
    end

    // Arbiter FSM and registered outputs; a stalled bus (HREADY=0) freezes everything.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q     <= DEF_GNT;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
`ifndef AHB_ARB_FIXED_PRIO_EN
            ptr_q       <= DEF_IDX;
`endif
        end else if (bus.HREADY) begin
            grant_q     <= grant_d;
            hmaster_q   <= grant_idx;
            hmastlock_q <= bus.HLOCK[grant_idx];
            cnt_q       <= cnt_d;
            state_q     <= state_d;
`ifndef AHB_ARB_FIXED_PRIO_EN
            if (grant_d != grant_q) begin
                ptr_q <= grant_d_idx;
            end
`endif
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = hmastlock_q;

    // A grant must always name exactly one master.
    assert property (@(posedge HCLK) disable iff (HRESET) $onehot(grant_q));

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - self-checking bench for ahb_arbiter against a behavioural model
module tb_ahb_arbiter;

    localparam int N   = 4;
    localparam int DEF = 0;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_INCR8 = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_arbiter #(
        .NUM_MASTERS   (N),
        .DEFAULT_MASTER(DEF)
    ) dut (
        .HCLK  (clk),
        .HRESET(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: who holds the grant, who owns the address phase, beats left, lock hold.
    int m_grant, m_master, m_cnt, m_ptr;
    bit m_lock, m_held;

    int inc_first, inc_t, lock_bad;
`ifdef AHB_ARB_FIXED_PRIO_EN
    int rr_grant[6] = '{2, 2, 2, 2, 2, 2};
    int rr_mast[6]  = '{0, 1, 1, 1, 1, 1};
    int p13_grant[6] = '{2, 2, 2, 2, 2, 2};
`else
    int rr_grant[6] = '{2, 4, 8, 2, 4, 8};
    int rr_mast[6]  = '{0, 1, 2, 3, 1, 2};
    int p13_grant[6] = '{2, 8, 2, 8, 2, 8};
`endif

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic int beats_of(input int hb);
        return (hb < 2) ? 1 : (4 << ((hb - 2) / 2));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict the outputs after the coming rising edge from the inputs now applied.
    task automatic model_step();
        int remaining, start, winner;
        if (rst) begin
            m_grant = DEF; m_master = DEF; m_lock = 0; m_cnt = 0; m_held = 0; m_ptr = DEF;
            return;
        end
        if (!bus.HREADY) return;
        case (bus.HTRANS)
            T_IDLE:   remaining = 0;
            T_BUSY:   remaining = m_cnt;
            T_NONSEQ: remaining = beats_of(int'(bus.HBURST)) - 1;
            default:  remaining = (m_cnt > 0) ? m_cnt - 1 : 0;
        endcase
        winner = m_grant;
        if (!m_held && !bit_at(bus.HLOCK, m_grant) && remaining <= 1) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
            start = N - 1;
`else
            start = m_ptr;
`endif
            winner = DEF;
            for (int k = N; k >= 1; k--) begin
                if (bit_at(bus.HBUSREQ, (start + k) % N)) winner = (start + k) % N;
            end
        end
        m_master = m_grant;
        m_lock   = bit_at(bus.HLOCK, m_grant);
        if (winner != m_grant) m_ptr = winner;
        m_grant  = winner;
        m_cnt    = remaining;
        m_held   = bit_at(bus.HLOCK, winner);
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_g;
        exp_g = N'(1) << m_grant;
        check("hgrant", 32'(bus.HGRANT), 32'(exp_g));
        check("hmaster", 32'(bus.HMASTER), 32'(m_master));
        check("hmastlock", 32'(bus.HMASTLOCK), 32'(m_lock));
        check("hgrant_onehot", $countones(bus.HGRANT), 1);
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lock,
                         input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HTRANS  = tr;
        bus.HBURST  = bu;
        bus.HREADY  = rdy;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, '0, T_IDLE, B_SINGLE, 1'b1);
        drive('0, '0, T_IDLE, B_SINGLE, 1'b1);
        rst = 1'b0;
    endtask

    task automatic incr4_beat(input logic [1:0] tr, input logic rdy);
        drive(4'b0100, '0, tr, B_INCR4, rdy);
        inc_t++;
        if (inc_first < 0 && bus.HGRANT == 4'b0100) inc_first = inc_t;
    endtask

    task automatic run_incr4(input int stall);
        do_reset();
        drive(4'b0001, '0, T_IDLE, B_SINGLE, 1'b1);
        inc_first = -1;
        inc_t     = 0;
        incr4_beat(T_NONSEQ, 1'b1);
        incr4_beat(T_SEQ, 1'b1);
        repeat (stall) incr4_beat(T_SEQ, 1'b0);
        check("incr4_hold_before_b3", 32'(bus.HGRANT), 32'd1);
        incr4_beat(T_SEQ, 1'b1);
        check("incr4_grant_b3", 32'(bus.HGRANT), 32'h4);
        check("incr4_hmaster_b3", 32'(bus.HMASTER), 32'd0);
        incr4_beat(T_SEQ, 1'b1);
        check("incr4_hmaster_b4", 32'(bus.HMASTER), 32'd2);
        check("incr4_switch_tick", inc_first, 3 + stall);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle bus: default master parked.
        do_reset();
        check("rst_hgrant", 32'(bus.HGRANT), 32'h1);
        check("rst_hmaster", 32'(bus.HMASTER), 32'd0);
        check("rst_hmastlock", 32'(bus.HMASTLOCK), 32'd0);
        repeat (20) drive('0, '0, T_IDLE, B_SINGLE, 1'b1);
        check("idle_hgrant", 32'(bus.HGRANT), 32'h1);
        check("idle_hmaster", 32'(bus.HMASTER), 32'd0);

        // M1..M3 with single transfers rotate.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(4'b1110, '0, T_NONSEQ, B_SINGLE, 1'b1);
            check("rr_grant", 32'(bus.HGRANT), rr_grant[i]);
            check("rr_hmaster", 32'(bus.HMASTER), rr_mast[i]);
        end

        // INCR4 by M0 with M2 waiting, without and with a 3-cycle stall.
        run_incr4(0);
        run_incr4(3);

        // Locked INCR8 pair by M1 keeps M3 out until the lock drops.
        do_reset();
        drive(4'b0010, 4'b0010, T_IDLE, B_SINGLE, 1'b1);
        check("lock_grant_taken", 32'(bus.HGRANT), 32'h2);
        lock_bad = 0;
        for (int b = 0; b < 16; b++) begin
            drive(4'b1010, 4'b0010, (b % 8 == 0) ? T_NONSEQ : T_SEQ, B_INCR8, 1'b1);
            if (bus.HGRANT != 4'b0010 || bus.HMASTLOCK != 1'b1) lock_bad++;
        end
        check("lock_m3_excluded", lock_bad, 0);
        drive(4'b1000, '0, T_IDLE, B_SINGLE, 1'b1);
        check("lock_release_hold", 32'(bus.HGRANT), 32'h2);
        drive(4'b1000, '0, T_IDLE, B_SINGLE, 1'b1);
        check("lock_release_m3", 32'(bus.HGRANT), 32'h8);

        // INCR8 cut short by IDLE after two beats.
        do_reset();
        drive(4'b0001, '0, T_IDLE, B_SINGLE, 1'b1);
        drive(4'b0100, '0, T_NONSEQ, B_INCR8, 1'b1);
        drive(4'b0100, '0, T_SEQ, B_INCR8, 1'b1);
        check("early_term_hold", 32'(bus.HGRANT), 32'h1);
        drive(4'b0100, '0, T_IDLE, B_SINGLE, 1'b1);
        check("early_term_switch", 32'(bus.HGRANT), 32'h4);

        // M1 and M3 competing.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(4'b1010, '0, T_NONSEQ, B_SINGLE, 1'b1);
            check("m1_m3_grant", 32'(bus.HGRANT), p13_grant[i]);
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(4'($urandom),
                  ($urandom_range(0, 3) == 0) ? (4'($urandom) & 4'($urandom)) : 4'b0000,
                  2'($urandom), 3'($urandom), $urandom_range(0, 4) != 0);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
